// File: rtl/gtp_arb_pkg.sv
// Shared types and helpers for the GTP TX arbiter: FSM states, tag header layout
// and the round-robin pick used when a new packet is granted.
package gtp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [7:0] HDR_MAGIC_DEFAULT = 8'hA5;
    localparam int         HDR_MAGIC_LSB     = 24;
    localparam int         HDR_SRC_LSB       = 8;
    localparam int         SRC_W             = 3;
    localparam int         MAX_SRC           = 8;

    // Tag word: magic in [31:24], source index in [10:8], every other bit zero.
    function automatic logic [31:0] build_hdr(input logic [7:0] magic,
                                              input logic [SRC_W-1:0] src);
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_MAGIC_LSB +: 8]     = magic;
        hdr[HDR_SRC_LSB +: SRC_W]   = src;
        return hdr;
    endfunction

    // First requester at index >= ptr, searching modulo num_src. Returns ptr if none.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                                 input logic [SRC_W-1:0]   ptr,
                                                 input logic [3:0]         num_src);
        logic [3:0]       idx;
        logic             found;
        logic [SRC_W-1:0] pick;
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < MAX_SRC; i++) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= num_src) begin
                idx = idx - num_src;
            end
            if (!found && (4'(i) < num_src) && req[idx[SRC_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[SRC_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop level synchroniser for slow status bits crossing into the local clock.
// Reused for any user_clk -> core_clk status signal.
module sync_2ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gtp_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the Aurora TX stream among NUM_SRC
// AXI-stream requesters; each granted packet is preceded by one tag header word.
module gtp_tx_arbiter
    import gtp_arb_pkg::*;
#(
    parameter int         NUM_SRC     = 4,
    parameter logic [7:0] HDR_MAGIC   = HDR_MAGIC_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  channel_up_async,
    input  logic [NUM_SRC*32-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]    s_tvalid,
    input  logic [NUM_SRC-1:0]    s_tlast,
    output logic [NUM_SRC-1:0]    s_tready,
    output logic [31:0]           m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic                  link_up,
    output logic [15:0]           pkt_cnt
);

    localparam logic [3:0]       NSRC     = 4'(NUM_SRC);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

    arb_state_e       state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] grant_id_q, grant_id_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;

    logic [MAX_SRC-1:0] req_pad;
    logic [31:0]        sel_tdata;
    logic               sel_tvalid;
    logic               sel_tlast;

    sync_2ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_link_sync (
        .clk (core_clk),
        .rst (reset),
        .d   (channel_up_async),
        .q   (link_up)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        req_pad              = '0;
        req_pad[NUM_SRC-1:0] = s_tvalid;
        sel_tdata            = '0;
        sel_tvalid           = 1'b0;
        sel_tlast            = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id_q == SRC_W'(i)) begin
                sel_tdata  = s_tdata[i*32 +: 32];
                sel_tvalid = s_tvalid[i];
                sel_tlast  = s_tlast[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        pkt_cnt_d  = pkt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Requester valids are only looked at here, and only while the link is up.
                if (link_up && (|s_tvalid)) begin
                    grant_id_d = rr_pick(req_pad, rr_ptr_q, NSRC);
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (m_tready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sel_tvalid && m_tready && sel_tlast) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    rr_ptr_d  = (grant_id_q == LAST_SRC) ? '0 : grant_id_q + 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // DATA is a pure pass-through so the source alone owns AXI stability there.
    always_comb begin
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tdata  = '0;
        s_tready = '0;
        case (state_q)
            ST_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = build_hdr(HDR_MAGIC, grant_id_q);
            end
            ST_DATA: begin
                m_tvalid = sel_tvalid;
                m_tlast  = sel_tlast;
                m_tdata  = sel_tdata;
                for (int i = 0; i < NUM_SRC; i++) begin
                    s_tready[i] = (grant_id_q == SRC_W'(i)) && m_tready;
                end
            end
            default: begin
                m_tvalid = 1'b0;
            end
        endcase
    end

    assign grant_id = grant_id_q;
    assign busy     = (state_q != ST_IDLE);
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_gtp_tx_arbiter.sv
// Scoreboard bench for gtp_tx_arbiter: per-source packet queues drive the inputs,
// expected output beats are queued by the tests and popped by an independent monitor.
module tb_gtp_tx_arbiter;

    localparam int NUM_SRC     = 4;
    localparam int SYNC_STAGES = 2;

    logic                  core_clk;
    logic                  reset;
    logic                  channel_up_async;
    logic [NUM_SRC*32-1:0] s_tdata;
    logic [NUM_SRC-1:0]    s_tvalid;
    logic [NUM_SRC-1:0]    s_tlast;
    logic [NUM_SRC-1:0]    s_tready;
    logic [31:0]           m_tdata;
    logic                  m_tvalid;
    logic                  m_tlast;
    logic                  m_tready;
    logic [2:0]            grant_id;
    logic                  busy;
    logic                  link_up;
    logic [15:0]           pkt_cnt;

    gtp_tx_arbiter #(
        .NUM_SRC     (NUM_SRC),
        .HDR_MAGIC   (8'hA5),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .core_clk         (core_clk),
        .reset            (reset),
        .channel_up_async (channel_up_async),
        .s_tdata          (s_tdata),
        .s_tvalid         (s_tvalid),
        .s_tlast          (s_tlast),
        .s_tready         (s_tready),
        .m_tdata          (m_tdata),
        .m_tvalid         (m_tvalid),
        .m_tlast          (m_tlast),
        .m_tready         (m_tready),
        .grant_id         (grant_id),
        .busy             (busy),
        .link_up          (link_up),
        .pkt_cnt          (pkt_cnt)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    int checks = 0;
    int errors = 0;

    logic [32:0] src_q [NUM_SRC][$];
    logic [32:0] exp_q [$];
    bit          bp_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input int src, input logic [31:0] base, input logic [31:0] step, input int n);
        for (int k = 0; k < n; k++) begin
            src_q[src].push_back({(k == n - 1), base + step * 32'(k)});
        end
    endtask

    task automatic exp_hdr(input int src);
        exp_q.push_back({1'b0, 8'hA5, 8'h00, 5'b0, 3'(src), 8'h00});
    endtask

    task automatic exp_pkt(input int src, input logic [31:0] base, input logic [31:0] step, input int n);
        exp_hdr(src);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({(k == n - 1), base + step * 32'(k)});
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge core_clk);
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge core_clk);
    endtask

    // Source and sink driver: handshakes sampled on negedge, queues advanced just after posedge.
    initial begin
        logic [NUM_SRC-1:0] fire;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        forever begin
            @(negedge core_clk);
            fire = s_tvalid & s_tready;
            @(posedge core_clk);
            #1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    s_tvalid[i]          = 1'b1;
                    s_tlast[i]           = src_q[i][0][32];
                    s_tdata[i*32 +: 32]  = src_q[i][0][31:0];
                end else begin
                    s_tvalid[i]          = 1'b0;
                    s_tlast[i]           = 1'b0;
                    s_tdata[i*32 +: 32]  = '0;
                end
            end
            m_tready = bp_mode ? ~m_tready : 1'b1;
        end
    end

    // Monitor: pops expectations on each output handshake and checks s_tready routing.
    initial begin
        bit                 in_data;
        bit                 hold_pending;
        logic [31:0]        hold_data;
        logic [2:0]         cur_src;
        logic [32:0]        e;
        logic [NUM_SRC-1:0] exp_rdy;
        in_data      = 1'b0;
        hold_pending = 1'b0;
        hold_data    = '0;
        cur_src      = '0;
        forever begin
            @(negedge core_clk);
            if (reset) begin
                in_data      = 1'b0;
                hold_pending = 1'b0;
            end else begin
                exp_rdy = in_data ? (NUM_SRC'(m_tready) << cur_src) : '0;
                check("s_tready", 64'(s_tready), 64'(exp_rdy));
                if (hold_pending) begin
                    check("hdr_hold", {31'b0, m_tvalid, m_tdata}, {31'b0, 1'b1, hold_data});
                end
                hold_pending = m_tvalid && !m_tready && !in_data;
                hold_data    = m_tdata;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'({m_tlast, m_tdata}), 64'h1_0000_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'({m_tlast, m_tdata}), 64'(e));
                        if (!in_data) begin
                            cur_src = e[10:8];
                            in_data = 1'b1;
                        end else if (m_tlast) begin
                            in_data = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string name);
        check({name, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
        check({name, "_m_tdata"},  64'(m_tdata),  64'd0);
        check({name, "_m_tlast"},  64'(m_tlast),  64'd0);
        check({name, "_s_tready"}, 64'(s_tready), 64'd0);
        check({name, "_busy"},     64'(busy),     64'd0);
        check({name, "_grant_id"}, 64'(grant_id), 64'd0);
        check({name, "_link_up"},  64'(link_up),  64'd0);
        check({name, "_pkt_cnt"},  64'(pkt_cnt),  64'd0);
    endtask

    initial begin
        int seen;
        int lat;
        reset            = 1'b1;
        channel_up_async = 1'b1;
        repeat (3) @(negedge core_clk);
        check_reset_outputs("reset");
        @(posedge core_clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge core_clk);
        check("link_up_after_sync", 64'(link_up), 64'd1);

        // All four requesters valid at once: rotation 0,1,2,3,0 with 2-word packets.
        load(0, 32'h0000_0A00, 32'd1, 2);
        load(0, 32'h0000_0B00, 32'd1, 2);
        load(1, 32'h0000_1A00, 32'd1, 2);
        load(2, 32'h0000_2A00, 32'd1, 2);
        load(3, 32'h0000_3A00, 32'd1, 2);
        exp_pkt(0, 32'h0000_0A00, 32'd1, 2);
        exp_pkt(1, 32'h0000_1A00, 32'd1, 2);
        exp_pkt(2, 32'h0000_2A00, 32'd1, 2);
        exp_pkt(3, 32'h0000_3A00, 32'd1, 2);
        exp_pkt(0, 32'h0000_0B00, 32'd1, 2);
        wait_drain("rotation");
        check("pkt_cnt_rotation", 64'(pkt_cnt), 64'd5);

        // Single source 1: A5000100, 11, 22, 33(last).
        load(1, 32'h11, 32'h11, 3);
        exp_q.push_back({1'b0, 32'hA500_0100});
        exp_q.push_back({1'b0, 32'h11});
        exp_q.push_back({1'b0, 32'h22});
        exp_q.push_back({1'b1, 32'h33});
        wait_drain("single");
        check("pkt_cnt_single", 64'(pkt_cnt), 64'd6);
        check("grant_id_single", 64'(grant_id), 64'd1);

        // rr_ptr is now 2: with 0 and 2 both requesting, 2 goes first.
        load(0, 32'h0000_0C00, 32'd1, 1);
        load(2, 32'h0000_2C00, 32'd1, 1);
        exp_pkt(2, 32'h0000_2C00, 32'd1, 1);
        exp_pkt(0, 32'h0000_0C00, 32'd1, 1);
        wait_drain("rr_after_single");
        check("pkt_cnt_rr", 64'(pkt_cnt), 64'd8);

        // Backpressure: m_tready toggles every cycle through HDR and DATA.
        bp_mode = 1'b1;
        load(3, 32'h0000_3D00, 32'd1, 3);
        exp_pkt(3, 32'h0000_3D00, 32'd1, 3);
        wait_drain("backpressure");
        bp_mode = 1'b0;
        repeat (2) @(negedge core_clk);
        check("pkt_cnt_bp", 64'(pkt_cnt), 64'd9);

        // Link gating.
        channel_up_async = 1'b0;
        repeat (4) @(negedge core_clk);
        check("link_down_sync", 64'(link_up), 64'd0);
        load(0, 32'h0000_0E00, 32'd1, 4);
        load(1, 32'h0000_1E00, 32'd1, 2);
        seen = 0;
        repeat (10) begin
            @(negedge core_clk);
            if (m_tvalid) seen++;
        end
        check("gated_no_valid", 64'(seen), 64'd0);
        exp_pkt(0, 32'h0000_0E00, 32'd1, 4);
        @(posedge core_clk);
        #1 channel_up_async = 1'b1;
        lat = 0;
        do begin
            @(negedge core_clk);
            lat++;
        end while (!m_tvalid && lat < 20);
        check("grant_latency_ok", 64'(lat >= SYNC_STAGES + 1 && lat <= SYNC_STAGES + 2), 64'd1);
        @(posedge core_clk);
        #1 channel_up_async = 1'b0;
        wait_drain("link_drop_mid_pkt");
        seen = 0;
        repeat (10) begin
            @(negedge core_clk);
            if (m_tvalid || busy) seen++;
        end
        check("no_grant_link_down", 64'(seen), 64'd0);
        check("pkt_cnt_link", 64'(pkt_cnt), 64'd10);
        exp_pkt(1, 32'h0000_1E00, 32'd1, 2);
        channel_up_async = 1'b1;
        wait_drain("link_restored");
        check("pkt_cnt_link2", 64'(pkt_cnt), 64'd11);

        // Reset during DATA word 2 of a source-2 packet.
        load(2, 32'h0000_2F00, 32'd1, 4);
        exp_hdr(2);
        exp_q.push_back({1'b0, 32'h0000_2F00});
        exp_q.push_back({1'b0, 32'h0000_2F01});
        seen = 0;
        while (exp_q.size() != 0 && seen < 100) begin
            @(negedge core_clk);
            #1;
            seen++;
        end
        check("reset_setup_reached", 64'(exp_q.size()), 64'd0);
        @(posedge core_clk);
        #2;
        check("data_word2_present", 64'(m_tdata), 64'h0000_2F02);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        repeat (2) @(negedge core_clk);
        @(posedge core_clk);
        #2 reset = 1'b0;
        // rr_ptr back to 0: source 1 wins over 3.
        load(1, 32'h0000_1700, 32'd1, 1);
        load(3, 32'h0000_3700, 32'd1, 1);
        exp_pkt(1, 32'h0000_1700, 32'd1, 1);
        exp_pkt(3, 32'h0000_3700, 32'd1, 1);
        wait_drain("after_reset");
        check("pkt_cnt_after_reset", 64'(pkt_cnt), 64'd2);

        // Counter wrap.
        @(negedge core_clk);
        force dut.pkt_cnt_q = 16'hFFFE;
        #1;
        release dut.pkt_cnt_q;
        #1;
        check("pkt_cnt_preload", 64'(pkt_cnt), 64'hFFFE);
        load(0, 32'h0000_0F00, 32'd1, 1);
        exp_pkt(0, 32'h0000_0F00, 32'd1, 1);
        wait_drain("wrap1");
        check("pkt_cnt_ffff", 64'(pkt_cnt), 64'hFFFF);
        load(2, 32'h0000_2E00, 32'd1, 1);
        exp_pkt(2, 32'h0000_2E00, 32'd1, 1);
        wait_drain("wrap2");
        check("pkt_cnt_wrap0", 64'(pkt_cnt), 64'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
